pipeline_ctrl: RTL and testbench

//  Pipeline hazard controller. Issues the hold/flush flags consumed by the IF/ID and ID/EX

---
 rtl/pipeline_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: arbitrates EX jumps, multi-cycle busy and load-use stalls into
// PC/IF-ID/ID-EX hold flags and a PC redirect. Optional perf counters under CTRL_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_jump_flag_in,
  input  logic [ADDR_WIDTH-1:0] ex_jump_addr_in,
  input  logic                  ex_busy_in,
  input  logic                  ex_load_in,
  input  logic [4:0]            ex_write_addr_in,
  input  logic [4:0]            id_reg1_addr_in,
  input  logic [4:0]            id_reg2_addr_in,
  output logic                  ctrl_jump_flag_out,
  output logic [ADDR_WIDTH-1:0] ctrl_jump_addr_out,
  output logic                  ctrl_pc_hold_out,
  output logic                  ctrl_ifd_hold_out,
  output logic                  ctrl_idd_hold_out,
  output logic [1:0]            ctrl_state_out
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]           ctrl_stall_cnt_out,
  output logic [31:0]           ctrl_flush_cnt_out
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    STALL = 2'd2,
    BUSY  = 2'd3
  } state_e;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  load_use;
  logic                  jump_c, pc_hold_c, ifd_hold_c, idd_hold_c;
  logic [ADDR_WIDTH-1:0] jaddr_c;

  assign load_use = ex_load_in && (ex_write_addr_in != 5'd0) &&
                    ((ex_write_addr_in == id_reg1_addr_in) ||
                     (ex_write_addr_in == id_reg2_addr_in));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    jump_c     = 1'b0;
    pc_hold_c  = 1'b0;
    ifd_hold_c = 1'b0;
    idd_hold_c = 1'b0;
    jaddr_c    = addr_q;
    if (state_q == FLUSH) begin
      // The instruction now in EX is already squashed, so any request it raises is ignored.
      ifd_hold_c = 1'b1;
      idd_hold_c = 1'b1;
      cnt_d      = cnt_q - 4'd1;
      if (cnt_q <= 4'd1) begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    end else if (ex_jump_flag_in) begin
      jump_c     = 1'b1;
      jaddr_c    = ex_jump_addr_in;
      addr_d     = ex_jump_addr_in;
      ifd_hold_c = 1'b1;
      idd_hold_c = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_INIT;
      end else begin
        state_d = RUN;
      end
    end else if (ex_busy_in) begin
      pc_hold_c  = 1'b1;
      ifd_hold_c = 1'b1;
      idd_hold_c = 1'b1;
      state_d    = BUSY;
    end else if (load_use && (state_q != BUSY)) begin
      pc_hold_c  = 1'b1;
      ifd_hold_c = 1'b1;
      idd_hold_c = 1'b1;
      state_d    = STALL;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Flags are combinational from EX, so they are gated while reset is asserted.
  assign ctrl_jump_flag_out = rst & jump_c;
  assign ctrl_jump_addr_out = rst ? jaddr_c : '0;
  assign ctrl_pc_hold_out   = rst & pc_hold_c;
  assign ctrl_ifd_hold_out  = rst & ifd_hold_c;
  assign ctrl_idd_hold_out  = rst & idd_hold_c;
  assign ctrl_state_out     = state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (pc_hold_c) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (jump_c)    flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign ctrl_stall_cnt_out = stall_cnt_q;
  assign ctrl_flush_cnt_out = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, async reset sequences, and randomized
// stimulus compared against a counter/flag based reference model.
module tb_pipeline_ctrl;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_jump_flag_in = 1'b0;
  logic [31:0] ex_jump_addr_in = '0;
  logic        ex_busy_in = 1'b0;
  logic        ex_load_in = 1'b0;
  logic [4:0]  ex_write_addr_in = '0;
  logic [4:0]  id_reg1_addr_in = '0;
  logic [4:0]  id_reg2_addr_in = '0;
  logic        ctrl_jump_flag_out;
  logic [31:0] ctrl_jump_addr_out;
  logic        ctrl_pc_hold_out;
  logic        ctrl_ifd_hold_out;
  logic        ctrl_idd_hold_out;
  logic [1:0]  ctrl_state_out;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] ctrl_stall_cnt_out;
  logic [31:0] ctrl_flush_cnt_out;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.FLUSH_CYCLES(FC), .ADDR_WIDTH(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .ex_jump_flag_in    (ex_jump_flag_in),
    .ex_jump_addr_in    (ex_jump_addr_in),
    .ex_busy_in         (ex_busy_in),
    .ex_load_in         (ex_load_in),
    .ex_write_addr_in   (ex_write_addr_in),
    .id_reg1_addr_in    (id_reg1_addr_in),
    .id_reg2_addr_in    (id_reg2_addr_in),
    .ctrl_jump_flag_out (ctrl_jump_flag_out),
    .ctrl_jump_addr_out (ctrl_jump_addr_out),
    .ctrl_pc_hold_out   (ctrl_pc_hold_out),
    .ctrl_ifd_hold_out  (ctrl_ifd_hold_out),
    .ctrl_idd_hold_out  (ctrl_idd_hold_out),
    .ctrl_state_out     (ctrl_state_out)
`ifdef CTRL_PERF_CNT_EN
    ,
    .ctrl_stall_cnt_out (ctrl_stall_cnt_out),
    .ctrl_flush_cnt_out (ctrl_flush_cnt_out)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        j;
    logic [31:0] a;
    logic        b;
    logic        l;
    logic [4:0]  rd, r1, r2;
    logic        ef, ep, ei, ed;
    logic [1:0]  es;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl[16];

  // Reference model state: remaining flush cycles, busy/stall residency, last target, counts.
  int          m_flush;
  bit          m_busy, m_stall;
  logic [31:0] m_addr;
  int unsigned m_stalls, m_jumps;

  task automatic drive(input logic j, input logic [31:0] a, input logic b, input logic l,
                       input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    ex_jump_flag_in  = j;
    ex_jump_addr_in  = a;
    ex_busy_in       = b;
    ex_load_in       = l;
    ex_write_addr_in = rd;
    id_reg1_addr_in  = r1;
    id_reg2_addr_in  = r2;
  endtask

  task automatic check(input string nm, input logic [37:0] act, input logic [37:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {flag,pc,ifd,idd,st,addr}=%h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [37:0] pack_out();
    return {ctrl_jump_flag_out, ctrl_pc_hold_out, ctrl_ifd_hold_out, ctrl_idd_hold_out,
            ctrl_state_out, ctrl_jump_addr_out};
  endfunction

  task automatic model_reset();
    m_flush = 0; m_busy = 0; m_stall = 0; m_addr = '0; m_stalls = 0; m_jumps = 0;
  endtask

  // Expected outputs for the current cycle; advances the model to the next cycle.
  task automatic model_eval(output logic [37:0] exp);
    logic f, p, i, d, lu;
    logic [1:0] st;
    logic [31:0] a;
    lu = ex_load_in && ex_write_addr_in != 0 &&
         (ex_write_addr_in == id_reg1_addr_in || ex_write_addr_in == id_reg2_addr_in);
    st = (m_flush > 0) ? 2'd1 : m_busy ? 2'd3 : m_stall ? 2'd2 : 2'd0;
    f = 0; p = 0; i = 0; d = 0; a = m_addr;
    if (m_flush > 0) begin
      i = 1; d = 1; m_flush--;
    end else if (ex_jump_flag_in) begin
      f = 1; i = 1; d = 1; a = ex_jump_addr_in; m_addr = ex_jump_addr_in;
      m_flush = FC - 1; m_busy = 0; m_stall = 0; m_jumps++;
    end else if (ex_busy_in) begin
      p = 1; i = 1; d = 1; m_busy = 1; m_stall = 0; m_stalls++;
    end else if (lu && !m_busy) begin
      p = 1; i = 1; d = 1; m_stall = 1; m_stalls++;
    end else begin
      m_busy = 0; m_stall = 0;
    end
    exp = {f, p, i, d, st, a};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [37:0] exp;

    // rows: inputs {j,a,b,l,rd,r1,r2} then expected {flag,pc,ifd,idd,state,addr}
    tbl[0]  = '{1, 32'h80,  0, 0, 0, 0, 0,  1, 0, 1, 1, 2'd0, 32'h80};
    tbl[1]  = '{0, 32'h0,   0, 0, 0, 0, 0,  0, 0, 1, 1, 2'd1, 32'h80};
    tbl[2]  = '{0, 32'h0,   0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0, 32'h80};
    tbl[3]  = '{0, 32'h0,   0, 1, 5, 0, 5,  0, 1, 1, 1, 2'd0, 32'h80};
    tbl[4]  = '{0, 32'h0,   0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd2, 32'h80};
    tbl[5]  = '{0, 32'h0,   0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0, 32'h80};
    tbl[6]  = '{0, 32'h0,   0, 1, 0, 0, 0,  0, 0, 0, 0, 2'd0, 32'h80};
    tbl[7]  = '{0, 32'h0,   1, 0, 0, 0, 0,  0, 1, 1, 1, 2'd0, 32'h80};
    tbl[8]  = '{0, 32'h0,   1, 0, 0, 0, 0,  0, 1, 1, 1, 2'd3, 32'h80};
    tbl[9]  = '{0, 32'h0,   1, 0, 0, 0, 0,  0, 1, 1, 1, 2'd3, 32'h80};
    tbl[10] = '{0, 32'h0,   1, 0, 0, 0, 0,  0, 1, 1, 1, 2'd3, 32'h80};
    tbl[11] = '{0, 32'h0,   0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd3, 32'h80};
    tbl[12] = '{0, 32'h0,   0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0, 32'h80};
    tbl[13] = '{1, 32'h100, 1, 1, 3, 3, 0,  1, 0, 1, 1, 2'd0, 32'h100};
    tbl[14] = '{1, 32'h200, 1, 0, 0, 0, 0,  0, 0, 1, 1, 2'd1, 32'h100};
    tbl[15] = '{0, 32'h0,   0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0, 32'h100};

    // Reset held with random activity on the inputs
    for (int c = 0; c < 5; c++) begin
      drive(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), 1'b1,
            5'd7, 5'd7, 5'($urandom_range(31)));
      #3;
      check($sformatf("reset_hold%0d", c), pack_out(), 38'd0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].j, tbl[i].a, tbl[i].b, tbl[i].l, tbl[i].rd, tbl[i].r1, tbl[i].r2);
      #3;
      check($sformatf("vec%0d", i), pack_out(),
            {tbl[i].ef, tbl[i].ep, tbl[i].ei, tbl[i].ed, tbl[i].es, tbl[i].ea});
      tick();
    end

    // Asynchronous reset in the middle of a BUSY period
    drive(0, 0, 1, 0, 0, 0, 0);
    tick();
    tick();
    #1;
    check("busy_before_rst", pack_out(), {1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 32'h100});
    rst = 1'b0;
    #1;
    check("busy_async_rst", pack_out(), 38'd0);
`ifdef CTRL_PERF_CNT_EN
    check("perf_after_rst", {6'd0, ctrl_stall_cnt_out | ctrl_flush_cnt_out}, 38'd0);
`endif
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #3;
    check("after_rst_release", pack_out(), 38'd0);
    tick();

    // Randomized traffic against the reference model (DUT state is RUN, addr 0)
    model_reset();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(7) == 0, $urandom, $urandom_range(3) == 0, $urandom_range(2) == 0,
            5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
`ifdef CTRL_PERF_CNT_EN
      check($sformatf("perf%0d", c), {6'd0, ctrl_stall_cnt_out ^ ctrl_flush_cnt_out},
            {6'd0, m_stalls ^ m_jumps});
`endif
      model_eval(exp);
      #2;
      check($sformatf("rand%0d", c), pack_out(), exp);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
